// File: rtl/alu_mdu.sv
`default_nettype none
// ============================================================================
// Module   : alu_mdu
// Brief    : RV base ALU plus M-extension with valid/ready handshake; MUL/DIV
//            are iterative. Define FAST_MUL_EN for a single-cycle multiplier.
// Revision : 1.0
// ============================================================================
module alu_mdu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] d1,
    input  logic [XLEN-1:0] d2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);
    localparam int SHW = $clog2(XLEN);
    localparam logic [SHW-1:0]  c_last = SHW'(XLEN - 1);
    localparam logic [XLEN-1:0] c_min  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MUL  = 3'd1,
        DIV  = 3'd2,
        FIN  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t            r_state, w_next;
    logic [SHW-1:0]    r_cnt;
    logic [2:0]        r_f3;
    logic              r_neg;
    logic [XLEN-1:0]   r_a;
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_result;

    logic              w_accept;
    logic [2:0]        w_f3;
    logic              w_s1, w_s2, w_n1, w_n2, w_neg;
    logic [XLEN-1:0]   w_m1, w_m2;
    logic              w_dz, w_ovf, w_special, w_direct;
    logic [XLEN-1:0]   w_spec_val, w_direct_val, w_alu;
    logic [SHW-1:0]    w_sh;

    assign in_ready  = (r_state == IDLE) || ((r_state == DONE) && out_ready);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state == MUL) || (r_state == DIV) || (r_state == FIN);
    assign result    = r_result;
    assign w_accept  = in_valid && in_ready && !flush;

    // Operand signedness per funct3: MUL/MULH/DIV/REM s*s, MULHSU s*u, rest u*u.
    assign w_f3  = op[2:0];
    assign w_s1  = w_f3[2] ? ~w_f3[0] : (w_f3[1:0] != 2'b11);
    assign w_s2  = w_f3[2] ? ~w_f3[0] : ~w_f3[1];
    assign w_n1  = w_s1 & d1[XLEN-1];
    assign w_n2  = w_s2 & d2[XLEN-1];
    assign w_m1  = w_n1 ? -d1 : d1;
    assign w_m2  = w_n2 ? -d2 : d2;
    assign w_neg = (w_f3[2] & w_f3[1]) ? w_n1 : (w_n1 ^ w_n2);

    assign w_dz       = (d2 == '0);
    assign w_ovf      = ~w_f3[0] & (d1 == c_min) & (d2 == '1);
    assign w_special  = op[4] & op[2] & (w_dz | w_ovf);
    assign w_spec_val = w_dz ? (w_f3[1] ? d1 : '1) : (w_f3[1] ? '0 : d1);

    assign w_sh = d2[SHW-1:0];
    always_comb begin
        w_alu = '0;
        case (op[3:0])
            4'b0000: w_alu = d1 + d2;
            4'b0001: w_alu = d1 << w_sh;
            4'b0010: w_alu = {{(XLEN-1){1'b0}}, $signed(d1) < $signed(d2)};
            4'b0011: w_alu = {{(XLEN-1){1'b0}}, d1 < d2};
            4'b0100: w_alu = d1 ^ d2;
            4'b0101: w_alu = d1 >> w_sh;
            4'b0110: w_alu = d1 | d2;
            4'b0111: w_alu = d1 & d2;
            4'b1000: w_alu = d1 - d2;
            4'b1101: w_alu = $unsigned($signed(d1) >>> w_sh);
            default: w_alu = '0;
        endcase
    end

`ifdef FAST_MUL_EN
    logic [2*XLEN-1:0] w_x1, w_x2, w_fprod;
    logic [XLEN-1:0]   w_fast_val;
    assign w_x1         = {{XLEN{w_n1}}, d1};
    assign w_x2         = {{XLEN{w_n2}}, d2};
    assign w_fprod      = w_x1 * w_x2;
    assign w_fast_val   = (w_f3[1:0] == 2'b00) ? w_fprod[XLEN-1:0] : w_fprod[2*XLEN-1:XLEN];
    assign w_direct     = ~op[4] | ~op[2] | w_special;
    assign w_direct_val = ~op[4] ? w_alu : (~op[2] ? w_fast_val : w_spec_val);
`else
    assign w_direct     = ~op[4] | w_special;
    assign w_direct_val = ~op[4] ? w_alu : w_spec_val;
`endif

    // Shift-add multiply: multiplier sits in the low half and drains out right.
    logic [XLEN:0]     w_madd;
    logic [2*XLEN-1:0] w_mstep;
    assign w_madd  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_a} : '0);
    assign w_mstep = {w_madd, r_acc[XLEN-1:1]};

    // Restoring divide: {remainder, dividend} shifts left, quotient bits fill in.
    logic [XLEN:0]     w_top;
    logic              w_ge;
    logic [XLEN-1:0]   w_sub;
    logic [2*XLEN-1:0] w_dstep;
    assign w_top   = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
    assign w_ge    = (w_top >= {1'b0, r_a});
    assign w_sub   = w_top[XLEN-1:0] - r_a;
    assign w_dstep = {(w_ge ? w_sub : w_top[XLEN-1:0]), r_acc[XLEN-2:0], w_ge};

    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_q, w_r, w_fin;
    assign w_prod = r_neg ? -r_acc : r_acc;
    assign w_q    = r_neg ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
    assign w_r    = r_neg ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];
    assign w_fin  = r_f3[2] ? (r_f3[1] ? w_r : w_q)
                  : ((r_f3[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (flush) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (w_accept) begin
                        if (w_direct)   w_next = DONE;
                        else if (op[2]) w_next = DIV;
                        else            w_next = MUL;
                    end else if ((r_state == DONE) && out_ready) begin
                        w_next = IDLE;
                    end
                end
                MUL, DIV: if (r_cnt == c_last) w_next = FIN;
                FIN:      w_next = DONE;
                default:  w_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_f3     <= '0;
            r_neg    <= 1'b0;
            r_a      <= '0;
            r_acc    <= '0;
            r_result <= '0;
        end else if (flush) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= '0;
            r_f3  <= op[2:0];
            r_neg <= w_neg;
            r_a   <= op[2] ? w_m2 : w_m1;
            r_acc <= {{XLEN{1'b0}}, (op[2] ? w_m1 : w_m2)};
            if (w_direct) r_result <= w_direct_val;
        end else begin
            case (r_state)
                MUL: begin
                    r_acc <= w_mstep;
                    r_cnt <= r_cnt + 1'b1;
                end
                DIV: begin
                    r_acc <= w_dstep;
                    r_cnt <= r_cnt + 1'b1;
                end
                FIN:     r_result <= w_fin;
                default: ;
            endcase
        end
    end
endmodule
`default_nettype wire
